// File: rtl/branch_ctrl_stage_pkg.sv
// Shared opcode constants, FSM state encoding and decode helpers for the
// ID-stage branch/jump control slice.
package mips_pkg;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_OPND,
        ST_ISSUE,
        ST_FLUSH
    } state_e;

    function automatic logic is_cond_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    // JAL redirects exactly like J; the link write is handled elsewhere.
    function automatic logic is_jump(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/branch_ctrl_stage_if.sv
// IF/ID-side inputs and PC-mux/hazard-side outputs of the branch control stage.
interface branch_ctrl_stage_if #(
    parameter int unsigned CNT_W = 16
);
    logic             if_valid;
    logic [31:0]      instr;
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
    logic             operands_ready;
    logic             branch;
    logic             jump;
    logic             zero;
    logic [31:0]      Extend;
    logic [25:0]      instr26;
    logic             stall_if;
    logic             flush_ifid;
    logic [CNT_W-1:0] taken_count;

    modport master (
        input  if_valid, instr, rs_data, rt_data, operands_ready,
        output branch, jump, zero, Extend, instr26, stall_if, flush_ifid, taken_count
    );

    modport slave (
        output if_valid, instr, rs_data, rt_data, operands_ready,
        input  branch, jump, zero, Extend, instr26, stall_if, flush_ifid, taken_count
    );
endinterface

// File: rtl/branch_ctrl_stage_cmp.sv
// Operand comparator: BEQ/BNE condition select; any other opcode yields zero=0.
module branch_cmp
    import mips_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic        o_zero
);
    always_comb begin
        o_zero = 1'b0;
        case (i_op)
            OP_BEQ:  o_zero = (i_rs == i_rt);
            OP_BNE:  o_zero = (i_rs != i_rt);
            default: o_zero = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_ctrl_stage.sv
// ID-stage branch/jump issue FSM: registered one-cycle issue pulse to the PC mux,
// fetch stall while operands resolve, wrong-path flush and taken-redirect counter.
module branch_ctrl_stage
    import mips_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned PC_SKEW      = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic         clk,
    input  logic         reset,
    branch_ctrl_stage_if.master bif
);
    localparam logic [1:0]  FLUSH_LAST = 2'(FLUSH_CYCLES - 1);
    localparam logic [31:0] SKEW       = 32'(PC_SKEW);

    state_e           r_state;
    logic [31:0]      r_instr;
    logic [1:0]       r_flush_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_branch, r_jump, r_zero, r_stall, r_flush;
    logic [31:0]      r_extend;
    logic [25:0]      r_instr26;

    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic        w_is_br, w_is_j, w_zero, w_accept, w_taken;
    logic [31:0] w_ext;

    // While waiting on operands the held copy is authoritative, not IF/ID.
    assign w_instr  = (r_state == ST_WAIT_OPND) ? r_instr : bif.instr;
    assign w_op     = w_instr[31:26];
    assign w_is_br  = is_cond_branch(w_op);
    assign w_is_j   = is_jump(w_op);
    assign w_ext    = {{16{w_instr[15]}}, w_instr[15:0]} - SKEW;
    assign w_taken  = (r_branch & r_zero) | r_jump;
    assign w_accept = ((r_state == ST_IDLE) && bif.if_valid &&
                       (w_is_j || (w_is_br && bif.operands_ready))) ||
                      ((r_state == ST_WAIT_OPND) && bif.operands_ready);

    branch_cmp u_cmp (
        .i_op   (w_op),
        .i_rs   (bif.rs_data),
        .i_rt   (bif.rt_data),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_instr     <= '0;
            r_flush_cnt <= '0;
            r_cnt       <= '0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
            r_zero      <= 1'b0;
            r_stall     <= 1'b0;
            r_flush     <= 1'b0;
            r_extend    <= '0;
            r_instr26   <= '0;
        end else begin
            r_branch  <= 1'b0;
            r_jump    <= 1'b0;
            r_zero    <= 1'b0;
            r_stall   <= 1'b0;
            r_flush   <= 1'b0;
            r_extend  <= '0;
            r_instr26 <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_accept && bif.if_valid && w_is_br) begin
                        r_state <= ST_WAIT_OPND;
                        r_instr <= bif.instr;
                        r_stall <= 1'b1;
                    end
                end
                ST_WAIT_OPND: begin
                    if (!w_accept) r_stall <= 1'b1;
                end
                ST_ISSUE: begin
                    if (w_taken) begin
                        r_state     <= ST_FLUSH;
                        r_flush     <= 1'b1;
                        r_flush_cnt <= FLUSH_LAST;
                        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == 2'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 2'd1;
                        r_flush     <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // Issue entry is shared by IDLE and WAIT_OPND and overrides the case above.
            if (w_accept) begin
                r_state   <= ST_ISSUE;
                r_stall   <= 1'b1;
                r_branch  <= w_is_br;
                r_jump    <= w_is_j;
                r_zero    <= w_zero;
                r_extend  <= w_ext;
                r_instr26 <= w_instr[25:0];
            end
        end
    end

    assign bif.branch      = r_branch;
    assign bif.jump        = r_jump;
    assign bif.zero        = r_zero;
    assign bif.Extend      = r_extend;
    assign bif.instr26     = r_instr26;
    assign bif.stall_if    = r_stall;
    assign bif.flush_ifid  = r_flush;
    assign bif.taken_count = r_cnt;
endmodule

// File: tb/tb_branch_ctrl_stage.sv
// Scoreboard bench: two configurations driven in lockstep, issue pulses checked
// against queued expectations, stall/flush/counter checked per transaction.
module tb_branch_ctrl_stage;
    import mips_pkg::*;

    localparam int unsigned FL_A = 1, FL_B = 2;
    localparam int unsigned SKEW_A = 1, SKEW_B = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] instr = '0, rs_data = '0, rt_data = '0;
    logic        operands_ready = 1'b0;

    always #5 clk = ~clk;

    branch_ctrl_stage_if #(.CNT_W(16)) ifa ();
    branch_ctrl_stage_if #(.CNT_W(4))  ifb ();

    assign ifa.if_valid = if_valid;
    assign ifa.instr = instr;
    assign ifa.rs_data = rs_data;
    assign ifa.rt_data = rt_data;
    assign ifa.operands_ready = operands_ready;
    assign ifb.if_valid = if_valid;
    assign ifb.instr = instr;
    assign ifb.rs_data = rs_data;
    assign ifb.rt_data = rt_data;
    assign ifb.operands_ready = operands_ready;

    branch_ctrl_stage #(.FLUSH_CYCLES(FL_A), .PC_SKEW(SKEW_A), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bif(ifa));
    branch_ctrl_stage #(.FLUSH_CYCLES(FL_B), .PC_SKEW(SKEW_B), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .bif(ifb));

    typedef struct packed {
        logic        br;
        logic        j;
        logic        z;
        logic [31:0] ext;
        logic [25:0] i26;
    } iss_t;

    iss_t qa[$], qb[$];
    iss_t ea, eb;
    int   n_tests = 0, n_fail = 0;
    int unsigned cnt_a = 0, cnt_b = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && (ifa.branch || ifa.jump)) begin
            chk("a_br_j_excl", 64'(ifa.branch & ifa.jump), 64'd0);
            if (qa.size() == 0) chk("a_unexpected_issue", 64'd1, 64'd0);
            else begin
                ea = qa.pop_front();
                chk("a_branch", 64'(ifa.branch), 64'(ea.br));
                chk("a_jump", 64'(ifa.jump), 64'(ea.j));
                chk("a_zero", 64'(ifa.zero), 64'(ea.z));
                chk("a_extend", 64'(ifa.Extend), 64'(ea.ext));
                chk("a_instr26", 64'(ifa.instr26), 64'(ea.i26));
            end
        end
        if (reset && (ifb.branch || ifb.jump)) begin
            chk("b_br_j_excl", 64'(ifb.branch & ifb.jump), 64'd0);
            if (qb.size() == 0) chk("b_unexpected_issue", 64'd1, 64'd0);
            else begin
                eb = qb.pop_front();
                chk("b_branch", 64'(ifb.branch), 64'(eb.br));
                chk("b_jump", 64'(ifb.jump), 64'(eb.j));
                chk("b_zero", 64'(ifb.zero), 64'(eb.z));
                chk("b_extend", 64'(ifb.Extend), 64'(eb.ext));
                chk("b_instr26", 64'(ifb.instr26), 64'(eb.i26));
            end
        end
    end

    task automatic run_op(input string tag, input logic [5:0] op, input logic [25:0] fld,
                          input logic [31:0] rs, input logic [31:0] rt, input int unsigned dly);
        logic is_br, is_j, z, taken;
        int unsigned st_a, fl_a, st_b, fl_b, exp_st;
        iss_t e;
        is_br = (op == 6'h04) || (op == 6'h05);
        is_j  = (op == 6'h02) || (op == 6'h03);
        z     = (op == 6'h04) ? (rs == rt) : (op == 6'h05) ? (rs != rt) : 1'b0;
        taken = (is_br && z) || is_j;
        if (is_br || is_j) begin
            e.br = is_br; e.j = is_j; e.z = z; e.i26 = fld;
            e.ext = {{16{fld[15]}}, fld[15:0]} - 32'(SKEW_A);
            qa.push_back(e);
            e.ext = {{16{fld[15]}}, fld[15:0]} - 32'(SKEW_B);
            qb.push_back(e);
        end
        st_a = 0; fl_a = 0; st_b = 0; fl_b = 0;
        @(negedge clk);
        instr = {op, fld};
        if_valid = 1'b1;
        operands_ready = (dly == 0);
        rs_data = rs;
        rt_data = (dly == 0) ? rt : ((rs == rt) ? ~rs : rs);
        for (int unsigned k = 1; k <= dly + 6; k++) begin
            @(negedge clk);
            st_a += 32'(ifa.stall_if); fl_a += 32'(ifa.flush_ifid);
            st_b += 32'(ifb.stall_if); fl_b += 32'(ifb.flush_ifid);
            if_valid = (k <= dly);
            if (k >= dly) begin
                operands_ready = 1'b1;
                rt_data = rt;
            end
        end
        if_valid = 1'b0;
        operands_ready = 1'b0;
        exp_st = is_br ? dly + 1 : (is_j ? 1 : 0);
        chk({tag, "_stall_a"}, 64'(st_a), 64'(exp_st));
        chk({tag, "_stall_b"}, 64'(st_b), 64'(exp_st));
        chk({tag, "_flush_a"}, 64'(fl_a), taken ? 64'(FL_A) : 64'd0);
        chk({tag, "_flush_b"}, 64'(fl_b), taken ? 64'(FL_B) : 64'd0);
        if (taken) begin
            cnt_a++;
            if (cnt_b < 15) cnt_b++;
        end
        chk({tag, "_count_a"}, 64'(ifa.taken_count), 64'(cnt_a));
        chk({tag, "_count_b"}, 64'(ifb.taken_count), 64'(cnt_b));
        chk({tag, "_qa_drained"}, 64'(qa.size()), 64'd0);
        chk({tag, "_qb_drained"}, 64'(qb.size()), 64'd0);
    endtask

    task automatic reset_in_issue();
        int unsigned fl;
        iss_t e;
        e.br = 1'b0; e.j = 1'b1; e.z = 1'b0; e.i26 = 26'h2A;
        e.ext = 32'h2A - 32'(SKEW_A);
        qa.push_back(e);
        e.ext = 32'h2A - 32'(SKEW_B);
        qb.push_back(e);
        @(negedge clk);
        instr = {6'h02, 26'h2A};
        if_valid = 1'b1;
        @(negedge clk);
        if_valid = 1'b0;
        chk("rst_pre_jump_a", 64'(ifa.jump), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("rst_jump_a", 64'(ifa.jump), 64'd0);
        chk("rst_stall_a", 64'(ifa.stall_if), 64'd0);
        chk("rst_jump_b", 64'(ifb.jump), 64'd0);
        chk("rst_stall_b", 64'(ifb.stall_if), 64'd0);
        chk("rst_count_a", 64'(ifa.taken_count), 64'd0);
        cnt_a = 0; cnt_b = 0;
        @(negedge clk);
        reset = 1'b1;
        fl = 0;
        for (int unsigned k = 0; k < 6; k++) begin
            @(negedge clk);
            fl += 32'(ifa.flush_ifid) + 32'(ifb.flush_ifid);
        end
        chk("rst_no_flush", 64'(fl), 64'd0);
        chk("rst_count_after_b", 64'(ifb.taken_count), 64'd0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctrl_a", 64'({ifa.branch, ifa.jump, ifa.zero, ifa.stall_if, ifa.flush_ifid}), 64'd0);
        chk("reset_data_a", 64'({ifa.Extend, ifa.instr26}), 64'd0);
        chk("reset_count_a", 64'(ifa.taken_count), 64'd0);
        chk("reset_ctrl_b", 64'({ifb.branch, ifb.jump, ifb.zero, ifb.stall_if, ifb.flush_ifid}), 64'd0);
        chk("reset_count_b", 64'(ifb.taken_count), 64'd0);
        reset = 1'b1;

        run_op("beq_eq",      6'h04, {10'h0, 16'h0003}, 32'd5, 32'd5, 0);
        run_op("bne_eq",      6'h05, {10'h0, 16'h0010}, 32'd7, 32'd7, 0);
        run_op("j_100",       6'h02, 26'h0000100, 32'd0, 32'd0, 0);
        run_op("jal",         6'h03, 26'h3FF8001, 32'd0, 32'd0, 0);
        run_op("beq_wait3",   6'h04, {10'h0, 16'h0040}, 32'd9, 32'd9, 3);
        run_op("bne_wait2",   6'h05, {10'h0, 16'hFFF0}, 32'hDEAD, 32'hBEEF, 2);
        run_op("beq_ne",      6'h04, {10'h0, 16'h8000}, 32'd1, 32'd2, 0);
        run_op("bne_wait1_eq", 6'h05, {10'h0, 16'h0000}, 32'h55, 32'h55, 1);
        run_op("non_branch",  6'h00, 26'h1234567, 32'd3, 32'd3, 0);

        reset_in_issue();

        for (int unsigned i = 0; i < 17; i++)
            run_op("sat_j", 6'h02, 26'(i), 32'd0, 32'd0, 0);
        chk("sat_hold_b", 64'(ifb.taken_count), 64'hF);
        chk("sat_free_a", 64'(ifa.taken_count), 64'd17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
